// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-port data-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned STARVE_W = 4;
  localparam int unsigned LAT_W    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed-priority grant (port 0 first) with a starvation guard for port 1.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic p0_req,
  input  logic p1_req,
  input  logic idle,
  input  logic handshake,
  output logic grant0,
  output logic grant1
);

  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;

  assign starved = (starve_cnt == STARVE_W'(STARVE_MAX));

  // Port 1 wins only when port 0 is absent or port 1 has waited long enough.
  always_comb begin
    grant1 = idle && p1_req && (!p0_req || starved);
    grant0 = idle && p0_req && !grant1;
  end

  // Count consecutive port-0 wins taken while port 1 was waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (idle) begin
      if (!p1_req || (handshake && grant1)) begin
        starve_cnt <= '0;
      end else if (handshake && grant0 && !starved) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter and sequencer for the single-port data memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t       state, state_d;
  logic [LAT_W-1:0] lat_cnt, lat_d;
  port_id_t         owner_q;
  logic             idle, grant0, grant1;
  logic             hs0, hs1, handshake, rd_done;

  // Readiness is suppressed while reset is held so no grant leaks out.
  assign idle      = rst_n && (state == IDLE);
  assign p0_ready  = grant0;
  assign p1_ready  = grant1;
  assign hs0       = p0_req && grant0;
  assign hs1       = p1_req && grant1;
  assign handshake = hs0 || hs1;
  assign rd_done   = (state == RDWAIT) && (lat_cnt == LAT_W'(1));

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_req    (p0_req),
    .p1_req    (p1_req),
    .idle      (idle),
    .handshake (handshake),
    .grant0    (grant0),
    .grant1    (grant1)
  );

  // State and read-latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_d;
      lat_cnt <= lat_d;
    end
  end

  // Next state: one ISSUE cycle per access, then RD_LAT wait cycles for reads.
  always_comb begin
    state_d = state;
    lat_d   = lat_cnt;
    case (state)
      IDLE: begin
        if (handshake) state_d = ISSUE;
      end
      ISSUE: begin
        if (mem_we) begin
          state_d = IDLE;
        end else begin
          state_d = RDWAIT;
          lat_d   = LAT_W'(RD_LAT);
        end
      end
      RDWAIT: begin
        if (lat_cnt == LAT_W'(1)) begin
          state_d = IDLE;
          lat_d   = '0;
        end else begin
          lat_d = lat_cnt - LAT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        lat_d   = '0;
      end
    endcase
  end

  // Memory drive is loaded on the handshake edge so it is valid during ISSUE;
  // read data is steered back to whichever port owns the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_sel   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner_q   <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      mem_sel   <= handshake;
      mem_we    <= 1'b0;
      p0_rvalid <= rd_done && (owner_q == 1'b0);
      p1_rvalid <= rd_done && (owner_q == 1'b1);
      if (handshake) begin
        mem_we    <= hs1 ? p1_we    : p0_we;
        mem_addr  <= hs1 ? p1_addr  : p0_addr;
        mem_wdata <= hs1 ? p1_wdata : p0_wdata;
        owner_q   <= port_id_t'(hs1);
      end
      if (rd_done && (owner_q == 1'b0)) p0_rdata <= mem_rdata;
      if (rd_done && (owner_q == 1'b1)) p1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned DW         = 32;
  localparam int unsigned AW         = 32;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req, p0_we, p0_ready, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_ready, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic          mem_sel, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] seed(int i);
    return 32'h00A5_0000 + 32'(i * 13);
  endfunction

  // Memory environment: 16 words, read data appears RD_LAT cycles after select.
  logic [31:0] emem [16];
  logic [31:0] pipe [RD_LAT];
  logic        load_mem;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++) emem[i] <= seed(i);
      for (int i = 0; i < int'(RD_LAT); i++) pipe[i] <= '0;
    end else begin
      if (mem_sel && mem_we) emem[mem_addr[3:0]] <= mem_wdata;
      if (mem_sel && !mem_we) pipe[0] <= emem[mem_addr[3:0]];
      for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mem_rdata = pipe[RD_LAT-1];

  // Reference model state (cycle-number bookkeeping, not an FSM copy).
  int          cyc, busy_until, wins, issue_cyc, rv_cyc;
  logic        issue_we, rv_port;
  logic [31:0] issue_addr, issue_wdata, rv_data, rd0, rd1;
  logic [31:0] mmem [16];
  logic        acc0, acc1, r0s, r1s, seen_rv0;
  logic [7:0]  sel_hist;
  int          n_total, n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    busy_until  = cyc;
    wins        = 0;
    issue_cyc   = -1;
    rv_cyc      = -1;
    issue_we    = 1'b0;
    issue_addr  = '0;
    issue_wdata = '0;
    rd0         = '0;
    rd1         = '0;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_mem_sel"},   mem_sel,   '0);
    chk({pfx, "_mem_we"},    mem_we,    '0);
    chk({pfx, "_mem_addr"},  mem_addr,  '0);
    chk({pfx, "_mem_wdata"}, mem_wdata, '0);
    chk({pfx, "_p0_ready"},  p0_ready,  '0);
    chk({pfx, "_p1_ready"},  p1_ready,  '0);
    chk({pfx, "_p0_rvalid"}, p0_rvalid, '0);
    chk({pfx, "_p1_rvalid"}, p1_rvalid, '0);
    chk({pfx, "_p0_rdata"},  p0_rdata,  '0);
    chk({pfx, "_p1_rdata"},  p1_rdata,  '0);
  endtask

  // One clock cycle: check DUT at the negedge against the model, then advance.
  task automatic cycle();
    logic free, g0, g1;
    @(negedge clk);
    free = (cyc >= busy_until);
    g0 = 1'b0;
    g1 = 1'b0;
    if (free) begin
      if (p1_req && (!p0_req || wins == int'(STARVE_MAX))) g1 = 1'b1;
      else if (p0_req) g0 = 1'b1;
    end
    if (cyc == rv_cyc) begin
      if (rv_port) rd1 = rv_data;
      else         rd0 = rv_data;
    end
    r0s = p0_ready;
    r1s = p1_ready;
    seen_rv0 = p0_rvalid;
    sel_hist = {sel_hist[6:0], mem_sel};
    chk("p0_ready", p0_ready, g0);
    chk("p1_ready", p1_ready, g1);
    chk("mem_sel", mem_sel, cyc == issue_cyc);
    chk("mem_we", mem_we, (cyc == issue_cyc) && issue_we);
    chk("mem_addr", mem_addr, issue_addr);
    chk("mem_wdata", mem_wdata, issue_wdata);
    chk("p0_rvalid", p0_rvalid, (cyc == rv_cyc) && !rv_port);
    chk("p1_rvalid", p1_rvalid, (cyc == rv_cyc) && rv_port);
    chk("p0_rdata", p0_rdata, rd0);
    chk("p1_rdata", p1_rdata, rd1);
    if (free) begin
      if (!p1_req || g1) wins = 0;
      else if (g0 && wins < int'(STARVE_MAX)) wins++;
    end
    acc0 = g0;
    acc1 = g1;
    if (g0 || g1) begin
      issue_cyc   = cyc + 1;
      issue_we    = g1 ? p1_we    : p0_we;
      issue_addr  = g1 ? p1_addr  : p0_addr;
      issue_wdata = g1 ? p1_wdata : p0_wdata;
      if (issue_we) begin
        mmem[issue_addr[3:0]] = issue_wdata;
        busy_until = cyc + 2;
      end else begin
        rv_cyc     = cyc + 2 + int'(RD_LAT);
        rv_port    = g1;
        rv_data    = mmem[issue_addr[3:0]];
        busy_until = rv_cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic rand_txn(input int port);
    logic [31:0] a;
    a = ($urandom() & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15));
    drive(port, 1'b1, 1'($urandom_range(0, 1)), a, $urandom());
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_txn(input int port, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    drive(port, 1'b1, we, a, d);
    for (int k = 0; k < 60; k++) begin
      cycle();
      if ((port == 0 && r0s) || (port == 1 && r1s)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("txn_accept", ok, 1'b1);
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
  endtask

  initial begin
    int h, lat, n0, n, hsc[3];
    logic got1;
    n_total = 0; n_bad = 0; cyc = 0; sel_hist = '0;
    acc0 = 0; acc1 = 0; r0s = 0; r1s = 0; seen_rv0 = 0; rv_port = 0; rv_data = '0;
    rst_n = 1'b0; load_mem = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 16; i++) mmem[i] = seed(i);
    model_reset();
    @(posedge clk); #1;
    chk_zero("por");
    @(posedge clk); #1;
    load_mem = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // p0 write then read, with measured read latency
    do_txn(0, 1'b1, 32'd8, 32'd3);
    chk("t1_issue_sel", mem_sel, 1'b1);
    chk("t1_issue_addr", mem_addr, 32'd8);
    do_txn(0, 1'b0, 32'd8, 32'd0);
    h = cyc - 1;
    lat = 0;
    for (int k = 0; k < 12; k++) begin
      int c;
      c = cyc;
      cycle();
      if (seen_rv0) begin lat = c - h; break; end
    end
    chk("t1_latency", lat, 2 + RD_LAT);
    chk("t1_rdata", p0_rdata, 32'd3);

    // write 4 to addr 9, read it back with we=0
    do_txn(0, 1'b1, 32'd9, 32'd4);
    do_txn(0, 1'b0, 32'd9, 32'd0);
    idle_cycles(RD_LAT + 2);
    chk("t2_rdata", p0_rdata, 32'd4);

    // simultaneous reads: p0 first, p1 next
    drive(0, 1'b1, 1'b0, 32'd1, '0);
    drive(1, 1'b1, 1'b0, 32'd2, '0);
    cycle();
    chk("t3_p0_first", r0s, 1'b1);
    chk("t3_p1_waits", r1s, 1'b0);
    p0_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (r1s) break;
    end
    p1_req = 1'b0;
    idle_cycles(RD_LAT + 3);
    chk("t3_p0_data", p0_rdata, seed(1));
    chk("t3_p1_data", p1_rdata, seed(2));

    // starvation guard, two rounds to confirm the counter restarts
    for (int round = 0; round < 2; round++) begin
      n0 = 0; got1 = 1'b0;
      drive(1, 1'b1, 1'b0, 32'd5, '0);
      if (round == 0) drive(0, 1'b1, 1'b1, 32'd12, $urandom());
      for (int k = 0; k < 60; k++) begin
        cycle();
        if (r1s) begin got1 = 1'b1; break; end
        if (r0s) begin
          n0++;
          drive(0, 1'b1, 1'b1, 32'd12, $urandom());
        end
      end
      chk("t4_p1_served", got1, 1'b1);
      chk("t4_p0_wins", n0, STARVE_MAX);
      p1_req = 1'b0;
    end
    p0_req = 1'b0;
    idle_cycles(RD_LAT + 3);

    // p1 back-to-back writes with request held
    for (int i = 0; i < 3; i++) hsc[i] = 0;
    n = 0;
    drive(1, 1'b1, 1'b1, 32'd0, 32'h1111_0000);
    for (int k = 0; k < 30; k++) begin
      int c;
      c = cyc;
      cycle();
      if (r1s) begin
        hsc[n] = c;
        n++;
        if (n == 3) begin p1_req = 1'b0; break; end
        drive(1, 1'b1, 1'b1, 32'(n * 4), 32'h1111_0000 + 32'(n));
      end
    end
    p1_req = 1'b0;
    cycle();
    chk("t5_gap01", hsc[1] - hsc[0], 2);
    chk("t5_gap12", hsc[2] - hsc[1], 2);
    chk("t5_sel_pattern", {27'd0, sel_hist[4:0]}, 32'b10101);
    idle_cycles(2);

    // reset during RDWAIT
    do_txn(0, 1'b0, 32'd3, '0);
    drive(1, 1'b1, 1'b1, 32'd6, 32'hCAFE_0006);
    cycle();
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("t6_grant_from_idle", p1_ready, 1'b1);
    cycle();
    p1_req = 1'b0;
    idle_cycles(RD_LAT + 4);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      cycle();
      if (acc0) begin
        if ($urandom_range(0, 3) != 0) rand_txn(0);
        else p0_req = 1'b0;
      end else if (!p0_req) begin
        if ($urandom_range(0, 2) == 0) rand_txn(0);
      end else if ($urandom_range(0, 24) == 0) begin
        p0_req = 1'b0;
      end
      if (acc1) begin
        if ($urandom_range(0, 1) != 0) rand_txn(1);
        else p1_req = 1'b0;
      end else if (!p1_req) begin
        if ($urandom_range(0, 3) == 0) rand_txn(1);
      end else if ($urandom_range(0, 39) == 0) begin
        p1_req = 1'b0;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    idle_cycles(RD_LAT + 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory block (MEM) of the pipeline.
- Port 0 is the pipeline MEM stage; port 1 is the secondary master (program/data loader).
- Grants one access at a time, drives the memory's select, write-enable, address and write-data inputs from registers, and returns read data with a valid pulse.
- Fixed priority to port 0, with a starvation guard for port 1.

Parameters:
- DATA_W, 32, data width of memory and ports.
- ADDR_W, 32, address width (ALU result width).
- RD_LAT, 1, memory read latency in cycles after the select cycle; legal range 1..4.
- STARVE_MAX, 4, consecutive port-0 wins while port 1 waits before port 1 is forced; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 request; held with p0_we/p0_addr/p0_wdata stable until p0_ready.
- p0_we  in  1  1 = write, 0 = read.
- p0_addr  in  ADDR_W  access address.
- p0_wdata  in  DATA_W  write data.
- p0_ready  out  1  accept strobe; the transfer is taken on the edge where p0_req && p0_ready.
- p0_rvalid  out  1  one-cycle pulse; p0_rdata is valid.
- p0_rdata  out  DATA_W  read data, held until the next port-0 read completes.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ready, p1_rvalid, p1_rdata: identical set for port 1.
- mem_sel  out  1  memory select (SelectMem).
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset: asynchronous, active low. FSM returns to IDLE. All registers clear to 0. Outputs under reset: mem_sel=0, mem_we=0, mem_addr=0, mem_wdata=0, pX_ready=0, pX_rvalid=0, pX_rdata=0.
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE:
  - pX_ready = grant_X (combinational); at most one grant.
  - On a handshake edge: capture we, addr, wdata and owner into registers; go to ISSUE.
  - With no request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_sel=1; mem_we=we_q; mem_addr=addr_q; mem_wdata=wdata_q.
  - Write: next state IDLE.
  - Read: next state RDWAIT, with lat_cnt loaded to RD_LAT.
- RDWAIT (RD_LAT cycles):
  - mem_sel=0; mem_we=0.
  - On the last cycle (lat_cnt==1): capture mem_rdata into the owner's pX_rdata, set the owner's pX_rvalid for the next cycle only, and go to IDLE.
  - A new grant may be given in that same IDLE cycle.
- Outside IDLE: p0_ready = p1_ready = 0.
- Outside ISSUE: mem_sel = mem_we = 0; mem_addr and mem_wdata hold their last value.
- Throughput:
  - Write: 2 cycles per access.
  - Read: 2 + RD_LAT cycles from handshake to the rvalid cycle inclusive.
- Grant rules:
  - Default: p0 wins.
  - starve_cnt (4 bits) increments when p0 is granted while p1_req=1, saturating at STARVE_MAX.
  - starve_cnt clears when p1 is granted, or when p1_req=0 in IDLE.
  - When starve_cnt==STARVE_MAX and p1_req=1, p1 wins over p0.
- Simultaneous rvalid and a new handshake are legal and independent.
- A requester dropping req without ready is legal; nothing is issued for it.
- Reset mid-access: the access is aborted and no rvalid is produced. A write that already passed ISSUE stands in memory.
- Addresses and data pass through unmodified; there is no alignment check.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, RDWAIT};
  - port_id_t (1-bit owner);
  - localparam STARVE_W = 4.
- Sub-module mem_arb_prio: combinational grant plus the starve_cnt register.
  - Inputs: clk, rst_n, p0_req, p1_req, idle, handshake.
  - Outputs: grant0, grant1.

Test Plan:
- Single write then read, p0: write addr 8 data 3; ISSUE cycle shows mem_sel=1, mem_we=1, mem_addr=8, mem_wdata=3. Then read addr 8; p0_rvalid=1 with p0_rdata=3 exactly 2+RD_LAT cycles after the handshake.
- Write with WE=0, which is a read: p0 read addr 9 after data 4 was written there -> mem_we stays 0 throughout; p0_rdata=4.
- Simultaneous requests: p0 and p1 both request reads in the same IDLE cycle -> p0_ready=1, p1_ready=0; p1 is served next; p1_rvalid never coincides with p0's handshake owner.
- Starvation: p0 requests continuously and p1 holds its request -> after STARVE_MAX=4 p0 grants, the 5th grant goes to p1; starve_cnt returns to 0.
- Reset mid-read: assert rst_n=0 during RDWAIT -> all outputs go to 0 immediately; no rvalid after release; first post-reset request is granted from IDLE.
- Back-to-back: p1 performs 3 consecutive writes (addrs 0, 4, 8) with req held high -> p1_ready pulses every 2 cycles; mem_sel pattern is 1,0,1,0,1.
